// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, derived totals and the
// colour-bar helper used by the optional test pattern.
package vga_pkg;

    localparam int DEF_COLOR_BITS = 2;
    localparam int DEF_CNT_W      = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } bar_rgb_t;

    // Bar index bits map straight onto the three channels: 0 = black, 7 = white.
    function automatic bar_rgb_t bar_color(input logic [2:0] idx);
        bar_rgb_t c;
        c.r = idx[2];
        c.g = idx[1];
        c.b = idx[0];
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter, wrap pulse,
// active-area decode and sync decode at the configured polarity.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    logic in_sync;

    assign wrap    = step && (cnt == LAST);
    assign active  = (cnt < ACT_END);
    assign in_sync = (cnt >= SYNC_START) && (cnt < SYNC_END);
    assign sync    = in_sync ? POL : ~POL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_stream_controller.sv
// Programmable VGA timing generator with a req/valid pixel interface and
// registered RGB/sync outputs. Optional colour bars under VGA_TEST_PATTERN_EN.
module vga_stream_controller
    import vga_pkg::*;
#(
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  pix_req,
    input  logic                  pix_valid,
    input  logic [COLOR_BITS-1:0] red_in,
    input  logic [COLOR_BITS-1:0] green_in,
    input  logic [COLOR_BITS-1:0] blue_in,
    input  logic                  underflow_clr,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                  test_mode,
`endif
    output logic                  hs,
    output logic                  vs,
    output logic                  de,
    output logic [CNT_W-1:0]      x,
    output logic [CNT_W-1:0]      y,
    output logic                  frame_start,
    output logic [COLOR_BITS-1:0] red_out,
    output logic [COLOR_BITS-1:0] green_out,
    output logic [COLOR_BITS-1:0] blue_out,
    output logic                  underflow
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_active;
    logic             v_active;
    logic             h_sync;
    logic             v_sync;
    logic             area_active;

    vga_axis_counter #(
        .CNT_W (CNT_W),
        .ACTIVE(H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP),
        .POL   (HS_POL)
    ) u_h_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (enable),
        .cnt   (h_cnt),
        .wrap  (h_wrap),
        .active(h_active),
        .sync  (h_sync)
    );

    vga_axis_counter #(
        .CNT_W (CNT_W),
        .ACTIVE(V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP),
        .POL   (VS_POL)
    ) u_v_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap),
        .active(v_active),
        .sync  (v_sync)
    );

    // Request/valid: pix_req is high for every active position of a running
    // raster; the source must answer with pix_valid in the same cycle. There is
    // no stall path, so a request without valid loses that pixel (underflow).
    assign area_active = h_active & v_active;
    assign pix_req     = enable & area_active;

    logic [COLOR_BITS-1:0] red_d;
    logic [COLOR_BITS-1:0] green_d;
    logic [COLOR_BITS-1:0] blue_d;
    logic                  pix_miss;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = CNT_W + 3;

    logic [BAR_W-1:0]      bar_pos;
    bar_rgb_t              bar;
    logic [COLOR_BITS-1:0] bar_red;
    logic [COLOR_BITS-1:0] bar_green;
    logic [COLOR_BITS-1:0] bar_blue;

    // Eight equal bars across the active width: index = h*8/H_ACTIVE.
    assign bar_pos   = {h_cnt, 3'b000} / BAR_W'(H_ACTIVE);
    assign bar       = bar_color(bar_pos[2:0]);
    assign bar_red   = {COLOR_BITS{bar.r}};
    assign bar_green = {COLOR_BITS{bar.g}};
    assign bar_blue  = {COLOR_BITS{bar.b}};
    assign pix_miss  = pix_req & ~pix_valid & ~test_mode;

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (pix_req && (test_mode || !pix_valid)) begin
            red_d   = bar_red;
            green_d = bar_green;
            blue_d  = bar_blue;
        end else if (pix_req) begin
            red_d   = red_in;
            green_d = green_in;
            blue_d  = blue_in;
        end
    end
`else
    assign pix_miss = pix_req & ~pix_valid;

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (pix_req && pix_valid) begin
            red_d   = red_in;
            green_d = green_in;
            blue_d  = blue_in;
        end
    end
`endif

    // All outputs are captured from the same counter state, so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
        end else if (enable) begin
            hs          <= h_sync;
            vs          <= v_sync;
            de          <= area_active;
            x           <= h_cnt;
            y           <= v_cnt;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            red_out     <= red_d;
            green_out   <= green_d;
            blue_out    <= blue_d;
        end else begin
            // A pause must not stretch the frame marker into several pulses.
            frame_start <= 1'b0;
        end
    end

    // Sticky underflow; a new miss wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (pix_miss) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_stream_controller.sv
// Directed bench for vga_stream_controller: default 640x480 timing, a tiny
// raster for wrap/polarity, and a small-H/default-V raster for frame timing.
module tb_vga_stream_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       pix_valid = 1'b1;
    logic [1:0] red_in = '0;
    logic [1:0] green_in = '0;
    logic [1:0] blue_in = '0;
    logic       underflow_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // default-timing instance
    logic       d_req, d_hs, d_vs, d_de, d_fs, d_uf;
    logic [9:0] d_x, d_y;
    logic [1:0] d_r, d_g, d_b;
    // tiny raster: H 4/1/1/1, V 2/1/1/1, hs active-high
    logic       s_req, s_hs, s_vs, s_de, s_fs, s_uf;
    logic [9:0] s_x, s_y;
    logic [1:0] s_r, s_g, s_b;
    // small H, default V
    logic       v_req, v_hs, v_vs, v_de, v_fs, v_uf;
    logic [9:0] v_x, v_y;
    logic [1:0] v_r, v_g, v_b;

    always #5 clk = ~clk;

    vga_stream_controller dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_req(d_req), .pix_valid(pix_valid),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .underflow_clr(underflow_clr),
        .hs(d_hs), .vs(d_vs), .de(d_de), .x(d_x), .y(d_y), .frame_start(d_fs),
        .red_out(d_r), .green_out(d_g), .blue_out(d_b), .underflow(d_uf)
    );

    vga_stream_controller #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_req(s_req), .pix_valid(pix_valid),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .underflow_clr(underflow_clr),
        .hs(s_hs), .vs(s_vs), .de(s_de), .x(s_x), .y(s_y), .frame_start(s_fs),
        .red_out(s_r), .green_out(s_g), .blue_out(s_b), .underflow(s_uf)
    );

    vga_stream_controller #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1)
    ) dut_v (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_req(v_req), .pix_valid(pix_valid),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .underflow_clr(underflow_clr),
        .hs(v_hs), .vs(v_vs), .de(v_de), .x(v_x), .y(v_y), .frame_start(v_fs),
        .red_out(v_r), .green_out(v_g), .blue_out(v_b), .underflow(v_uf)
    );

    // Advance one clock; outputs are observed on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        pix_valid = 1'b1;
        underflow_clr = 1'b0;
        red_in = '0;
        green_in = '0;
        blue_in = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        tick();
        n_cmp++; if (d_hs !== 1'b1) begin n_bad++; $display("FAIL reset_hs got %0b want 1", d_hs); end
        n_cmp++; if (d_vs !== 1'b1) begin n_bad++; $display("FAIL reset_vs got %0b want 1", d_vs); end
        n_cmp++; if (d_de !== 1'b0) begin n_bad++; $display("FAIL reset_de got %0b want 0", d_de); end
        n_cmp++; if ({d_r, d_g, d_b} !== 6'd0) begin n_bad++; $display("FAIL reset_rgb got %h want 0", {d_r, d_g, d_b}); end
        n_cmp++; if (d_uf !== 1'b0) begin n_bad++; $display("FAIL reset_underflow got %0b want 0", d_uf); end
        n_cmp++; if (d_fs !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start got %0b want 0", d_fs); end
        n_cmp++; if (s_hs !== 1'b0) begin n_bad++; $display("FAIL reset_hs_pol1 got %0b want 0", s_hs); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (d_x !== 10'd0 || d_y !== 10'd0) begin n_bad++; $display("FAIL first_xy got %0d,%0d want 0,0", d_x, d_y); end
        n_cmp++; if (d_fs !== 1'b1) begin n_bad++; $display("FAIL first_frame_start got %0b want 1", d_fs); end
        n_cmp++; if (d_de !== 1'b1) begin n_bad++; $display("FAIL first_de got %0b want 1", d_de); end
        tick();
        n_cmp++; if (d_fs !== 1'b0 || d_x !== 10'd1) begin n_bad++; $display("FAIL second_cycle got fs=%0b x=%0d want fs=0 x=1", d_fs, d_x); end
    endtask

    task automatic test_pixels();
        int budget;
        do_reset();
        repeat (5) tick();
        // counter is now at h=5
        n_cmp++; if (d_x !== 10'd4) begin n_bad++; $display("FAIL pre_h5_x got %0d want 4", d_x); end
        n_cmp++; if (d_req !== 1'b1) begin n_bad++; $display("FAIL req_active got %0b want 1", d_req); end
        pix_valid = 1'b1; red_in = 2'b11; green_in = 2'b01; blue_in = 2'b10;
        tick();
        n_cmp++; if (d_x !== 10'd5 || d_r !== 2'd3 || d_g !== 2'd1 || d_b !== 2'd2) begin
            n_bad++; $display("FAIL pixel_h5 got x=%0d rgb=%0d%0d%0d want x=5 rgb=312", d_x, d_r, d_g, d_b);
        end
        n_cmp++; if (d_uf !== 1'b0) begin n_bad++; $display("FAIL no_underflow got %0b want 0", d_uf); end
        pix_valid = 1'b0;
        tick();
        n_cmp++; if (d_x !== 10'd6 || {d_r, d_g, d_b} !== 6'd0) begin
            n_bad++; $display("FAIL starved_rgb got x=%0d rgb=%h want x=6 rgb=0", d_x, {d_r, d_g, d_b});
        end
        n_cmp++; if (d_uf !== 1'b1) begin n_bad++; $display("FAIL underflow_set got %0b want 1", d_uf); end
        underflow_clr = 1'b1;
        tick();
        n_cmp++; if (d_uf !== 1'b1) begin n_bad++; $display("FAIL clr_vs_set got %0b want 1", d_uf); end
        pix_valid = 1'b1;
        tick();
        n_cmp++; if (d_uf !== 1'b0) begin n_bad++; $display("FAIL underflow_clr got %0b want 0", d_uf); end
        underflow_clr = 1'b0;
        red_in = 2'b10; green_in = 2'b11; blue_in = 2'b01;
        budget = 800;
        while (d_x !== 10'd639 && budget > 0) begin tick(); budget--; end
        n_cmp++; if (d_x !== 10'd639 || d_de !== 1'b1 || {d_r, d_g, d_b} !== 6'b10_11_01) begin
            n_bad++; $display("FAIL last_active got x=%0d de=%0b rgb=%h want x=639 de=1 rgb=2d", d_x, d_de, {d_r, d_g, d_b});
        end
        pix_valid = 1'b0;
        tick();
        n_cmp++; if (d_de !== 1'b0 || {d_r, d_g, d_b} !== 6'd0) begin
            n_bad++; $display("FAIL blank_rgb got de=%0b rgb=%h want de=0 rgb=0", d_de, {d_r, d_g, d_b});
        end
        n_cmp++; if (d_req !== 1'b0) begin n_bad++; $display("FAIL req_blank got %0b want 0", d_req); end
        repeat (5) tick();
        n_cmp++; if (d_uf !== 1'b0) begin n_bad++; $display("FAIL valid_ignored_blank got %0b want 0", d_uf); end
        pix_valid = 1'b1;
    endtask

    task automatic test_hsync();
        int budget;
        int low_cnt;
        int t0;
        logic [9:0] y0;
        do_reset();
        budget = 1000;
        while (d_x !== 10'd655 && budget > 0) begin tick(); budget--; end
        n_cmp++; if (d_hs !== 1'b1 || d_x !== 10'd655) begin n_bad++; $display("FAIL hs_before got hs=%0b x=%0d want hs=1 x=655", d_hs, d_x); end
        tick();
        n_cmp++; if (d_hs !== 1'b0) begin n_bad++; $display("FAIL hs_start got %0b want 0 at x=656", d_hs); end
        low_cnt = 0;
        while (d_hs === 1'b0 && low_cnt < 200) begin low_cnt++; tick(); end
        n_cmp++; if (low_cnt !== 96) begin n_bad++; $display("FAIL hs_width got %0d want 96", low_cnt); end
        n_cmp++; if (d_x !== 10'd752) begin n_bad++; $display("FAIL hs_end_x got %0d want 752", d_x); end
        budget = 1000;
        while (d_x !== 10'd0 && budget > 0) begin tick(); budget--; end
        t0 = cyc;
        y0 = d_y;
        tick();
        budget = 1000;
        while (d_x !== 10'd0 && budget > 0) begin tick(); budget--; end
        n_cmp++; if (cyc - t0 !== 800) begin n_bad++; $display("FAIL line_period got %0d want 800", cyc - t0); end
        n_cmp++; if (d_y !== y0 + 10'd1) begin n_bad++; $display("FAIL line_y got %0d want %0d", d_y, y0 + 10'd1); end
    endtask

    task automatic test_small_timing();
        int ex, ey;
        do_reset();
        pix_valid = 1'b1; red_in = 2'd1; green_in = 2'd2; blue_in = 2'd3;
        for (int i = 0; i < 42; i++) begin
            tick();
            ex = i % 7;
            ey = (i / 7) % 5;
            n_cmp++; if (s_x !== 10'(ex) || s_y !== 10'(ey)) begin
                n_bad++; $display("FAIL small_xy cyc %0d got %0d,%0d want %0d,%0d", i, s_x, s_y, ex, ey);
            end
            n_cmp++; if (s_hs !== (ex == 5)) begin n_bad++; $display("FAIL small_hs cyc %0d got %0b want %0b", i, s_hs, ex == 5); end
            n_cmp++; if (s_vs !== (ey != 3)) begin n_bad++; $display("FAIL small_vs cyc %0d got %0b want %0b", i, s_vs, ey != 3); end
            n_cmp++; if (s_fs !== (ex == 0 && ey == 0)) begin n_bad++; $display("FAIL small_fs cyc %0d got %0b", i, s_fs); end
            n_cmp++; if ({s_r, s_g, s_b} !== ((ex < 4 && ey < 2) ? 6'b01_10_11 : 6'd0)) begin
                n_bad++; $display("FAIL small_rgb cyc %0d got %h", i, {s_r, s_g, s_b});
            end
        end
    endtask

    task automatic test_vsync_frame();
        int period, low_cnt, first_y, last_y;
        do_reset();
        tick();
        n_cmp++; if (v_fs !== 1'b1) begin n_bad++; $display("FAIL v_first_fs got %0b want 1", v_fs); end
        period = -1; low_cnt = 0; first_y = -1; last_y = -1;
        for (int c = 1; c <= 4000; c++) begin
            tick();
            if (v_vs === 1'b0) begin
                low_cnt++;
                if (first_y < 0) first_y = int'(v_y);
                last_y = int'(v_y);
            end
            if (v_fs === 1'b1) begin period = c; break; end
        end
        n_cmp++; if (period !== 3675) begin n_bad++; $display("FAIL frame_period got %0d want 3675", period); end
        n_cmp++; if (first_y !== 490 || last_y !== 491) begin n_bad++; $display("FAIL vs_lines got %0d..%0d want 490..491", first_y, last_y); end
        n_cmp++; if (low_cnt !== 14) begin n_bad++; $display("FAIL vs_width got %0d want 14", low_cnt); end
    endtask

    task automatic test_enable();
        int moved;
        do_reset();
        repeat (100) tick();
        // counter at h=100, output shows x=99
        enable = 1'b0;
        pix_valid = 1'b0;
        #1;
        n_cmp++; if (d_req !== 1'b0) begin n_bad++; $display("FAIL paused_req got %0b want 0", d_req); end
        moved = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (d_x !== 10'd99) moved++;
        end
        n_cmp++; if (moved !== 0) begin n_bad++; $display("FAIL paused_x moved %0d times want 0 (x=%0d)", moved, d_x); end
        n_cmp++; if (d_uf !== 1'b0) begin n_bad++; $display("FAIL paused_underflow got %0b want 0", d_uf); end
        enable = 1'b1;
        pix_valid = 1'b1;
        tick();
        n_cmp++; if (d_x !== 10'd100) begin n_bad++; $display("FAIL resume_x got %0d want 100", d_x); end
        tick();
        n_cmp++; if (d_x !== 10'd101) begin n_bad++; $display("FAIL resume_next_x got %0d want 101", d_x); end
    endtask

    task automatic test_reset_mid();
        pix_valid = 1'b0;
        tick();
        pix_valid = 1'b1; red_in = 2'b11; green_in = 2'b11; blue_in = 2'b11;
        tick();
        n_cmp++; if (d_uf !== 1'b1 || d_r !== 2'b11) begin n_bad++; $display("FAIL pre_reset got uf=%0b r=%0d want uf=1 r=3", d_uf, d_r); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (d_x !== 10'd0 || d_y !== 10'd0 || d_de !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_pos got x=%0d y=%0d de=%0b want 0,0,0", d_x, d_y, d_de);
        end
        n_cmp++; if (d_hs !== 1'b1 || d_vs !== 1'b1 || d_uf !== 1'b0 || {d_r, d_g, d_b} !== 6'd0) begin
            n_bad++; $display("FAIL mid_reset_out got hs=%0b vs=%0b uf=%0b rgb=%h want 1,1,0,0", d_hs, d_vs, d_uf, {d_r, d_g, d_b});
        end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_hsync();
        test_small_timing();
        test_vsync_frame();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
